fifo_drain_reader: RTL and testbench
====================================

# fifo_drain_reader

Read-side controller for the 64x8 FIFO. It keeps a shadow occupancy count from the FIFO's write strobes, because the FIFO exposes only overflow/underflow flags and no empty/full flags. It issues FIFO reads only when data is present, so it never underflows, and it re-times the read data into a valid/ready stream through a 2-entry skid buffer. It sits between the FIFO's `data_o`/`rd_en` pins and any downstream consumer, and sustains one word per cycle.

## Interface
- `DEPTH`, default 6: FIFO address bits; capacity is 2^DEPTH = 64 entries.
- `WIDTH`, default 8: data width.

- `clk`  in  1  rising-edge clock, shared with the FIFO.
- `reset`  in  1  asynchronous, active-high; the top level drives the FIFO's `reset_n` from the same source, inverted.
- `wr_seen`  in  1  copy of the FIFO's `wr_en`, sampled on `clk`.
- `fifo_rd_en`  out  1  to the FIFO's `rd_en`.
- `fifo_data`  in  WIDTH  from the FIFO's `data_o`; valid in the cycle after `rd_en` is sampled.
- `m_data`  out  WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `fifo_level`  out  DEPTH+1  shadow count of words held in the FIFO (0..64).
- `drop_err`  out  1  sticky; a write hit a full FIFO.

## Operation
- State registers:
  - `count` (DEPTH+1 bits)
  - `inflight` (1 bit): a read was issued last cycle
  - `occ` (0..2): skid entries held
  - `head`/`tail` skid registers
  - `drop_err`
- `pop` = `m_valid` & `m_ready`.
- `fifo_rd_en` = (`count` != 0) & (`occ` + `inflight` − `pop` < 2). It is combinational from registered state and `m_ready`.
- `wr_acc` = `wr_seen` & ((`count` != 2^DEPTH) | `fifo_rd_en`).
  - A write on a full FIFO in the same cycle as a read is accepted, matching the FIFO's behaviour.
  - A write on a full FIFO with no read is dropped: `count` is unchanged and `drop_err` is set.
- `count_next` = `count` + `wr_acc` − `fifo_rd_en`.
  - Simultaneous accept and read leave `count` unchanged.
  - `count` never wraps and never goes below 0.
- `inflight_next` = `fifo_rd_en`.
- Skid buffer:
  - When `inflight` = 1, `fifo_data` is captured at the clock edge into `head` if the buffer is empty after `pop`, otherwise into `tail`.
  - On `pop`, `tail` moves to `head`.
  - Order is strictly FIFO. No word is lost or duplicated.
- Outputs:
  - `m_valid` = (`occ` != 0).
  - `m_data` = `head`. It is held stable while `m_valid` & !`m_ready`.
- `drop_err` clears only on `reset`.
- Underflow is impossible by construction: `fifo_rd_en` is never high while `count` = 0.

## Timing
- Reset values, applied asynchronously and immediately on `reset`:
  - `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0
  - `fifo_level` = 0, `drop_err` = 0
  - internal `occ` = 0, `inflight` = 0
- Reset mid-stream discards the in-flight word and both skid entries. The FIFO is reset together with this block.
- Latency from `wr_seen` sampled at edge E with the pipeline empty:
  - `count` = 1 after E.
  - `fifo_rd_en` is high during cycle E..E+1 and is sampled at E+1.
  - The word is captured at E+2; `m_valid` = 1 after E+2. Total: 2 cycles.
- Throughput: one word per cycle while `m_ready` = 1 and `count` > 0.
- Backpressure:
  - At most 2 words sit outside the FIFO (`occ` + `inflight` ≤ 2).
  - Once `m_ready` drops, at most one further read is issued.
- `fifo_level` reflects the registered `count`, updated at each edge.

## Test plan
- Reset: assert `reset` between edges with random prior state. `m_valid`, `fifo_rd_en`, `fifo_level` and `drop_err` must read 0 immediately, before the next edge.
- Burst with `m_ready` = 1: write A0, A1, AA, AB, AC, AD on 6 consecutive edges.
  - `m_data` must be A0, A1, AA, AB, AC, AD on 6 consecutive cycles.
  - First `m_valid` appears 2 cycles after the first write edge.
  - `fifo_level` never exceeds 1.
  - The FIFO's `underflow` flag never asserts.
- Backpressure: `m_ready` = 0, write A0, A1, AA.
  - Exactly 2 `fifo_rd_en` pulses occur.
  - `fifo_level` settles at 1; `m_valid` = 1 with `m_data` = A0 held.
  - Raise `m_ready`: the output is A0, A1, AA on consecutive cycles, then `m_valid` = 0 and `fifo_level` = 0.
- Fill and overflow: `m_ready` = 0, 66 writes of the values 0..65.
  - `fifo_level` = 64 and `drop_err` = 0.
  - A 67th write sets `drop_err` = 1 and leaves `fifo_level` = 64.
  - Draining yields 0..65 in order, with 66 never appearing.
- Full with simultaneous read/write: at `fifo_level` = 64, raise `m_ready` while writing every cycle. `fifo_level` stays 64 and `drop_err` stays 0.
- Reset mid-stream: during the burst test, pulse `reset` after the third output word. All outputs return to 0. A following write of 55 emerges as the first word, 2 cycles after its write edge.

Source files
------------

// File: rtl/fifo_drain_reader.sv
// Read-side controller for a flag-only FIFO: shadow occupancy count, underflow-free
// read issue, and a 2-entry skid buffer presenting the data as a valid/ready stream.
module fifo_drain_reader #(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_seen,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DEPTH:0]   fifo_level,
  output logic             drop_err
);

  localparam int unsigned    CAP      = 1 << DEPTH;
  localparam logic [DEPTH:0] FULL_CNT = CAP[DEPTH:0];

  logic [DEPTH:0]   count, count_next;
  logic             inflight;
  logic [1:0]       occ, occ_after_pop, occ_next;
  logic [2:0]       outside;
  logic [WIDTH-1:0] head, tail;
  logic             pop, rd, wr_acc;

  always_comb begin
    pop           = m_valid & m_ready;
    occ_after_pop = occ - {1'b0, pop};
    outside       = {1'b0, occ_after_pop} + {2'b00, inflight};
    rd            = (count != '0) && (outside < 3'd2);
    // A write into a full FIFO still lands when the same edge also reads.
    wr_acc        = wr_seen & ((count != FULL_CNT) | rd);
    count_next    = count + {{DEPTH{1'b0}}, wr_acc} - {{DEPTH{1'b0}}, rd};
    occ_next      = occ_after_pop + {1'b0, inflight};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      inflight <= 1'b0;
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
      drop_err <= 1'b0;
    end else begin
      count    <= count_next;
      inflight <= rd;
      occ      <= occ_next;
      if (wr_seen && !wr_acc)
        drop_err <= 1'b1;
      if (pop)
        head <= tail;
      // Arriving word goes to head when the buffer drains empty this edge; overrides the shift.
      if (inflight) begin
        if (occ_after_pop == 2'd0)
          head <= fifo_data;
        else
          tail <= fifo_data;
      end
    end
  end

  always_comb begin
    fifo_rd_en = rd;
    fifo_level = count;
    m_valid    = (occ != 2'd0);
    m_data     = head;
  end

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Randomized and directed bench for fifo_drain_reader with a queue-based FIFO
// environment and an end-to-end stream scoreboard.
module tb_fifo_drain_reader;
  localparam int DEPTH = 6;
  localparam int WIDTH = 8;
  localparam int CAP   = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_seen = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic [DEPTH:0]   fifo_level;
  logic             drop_err;

  always #5 clk = ~clk;

  fifo_drain_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .wr_seen(wr_seen), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .drop_err(drop_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               drop_model;
  int               edges;
  int               rd_pulses, pops, first_pop_edge, last_pop_edge, first_valid_edge;
  int               max_level, min_level;
  logic [WIDTH-1:0] last_pop;
  bit               hold_prev;
  logic [WIDTH-1:0] hold_data;

  task automatic clear_stats();
    rd_pulses = 0; pops = 0; first_pop_edge = -1; last_pop_edge = -1;
    first_valid_edge = -1; max_level = 0; min_level = 999;
  endtask

  // One clock period: sample in the low phase, advance the FIFO model, cross the edge.
  task automatic cycle();
    logic [WIDTH-1:0] fd_next;
    logic             rd;
    #1;
    rd = fifo_rd_en;
    if (rd) rd_pulses++;
    check("underflow", {31'd0, rd && fifo_q.size() == 0}, 0);
    check("level", fifo_level, fifo_q.size());
    check("drop_err", drop_err, drop_model);
    check("outside", {31'd0, (int'(exp_q.size()) - int'(fifo_q.size())) <= 2}, 1);
    if (hold_prev) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, hold_data);
    end
    hold_prev = m_valid && !m_ready;
    hold_data = m_data;
    if (int'(fifo_level) > max_level) max_level = fifo_level;
    if (int'(fifo_level) < min_level) min_level = fifo_level;
    if (m_valid && first_valid_edge < 0) first_valid_edge = edges;
    if (m_valid && m_ready) begin
      check("pop_nonempty", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) check("data", m_data, exp_q.pop_front());
      pops++;
      last_pop = m_data;
      if (first_pop_edge < 0) first_pop_edge = edges;
      last_pop_edge = edges;
    end
    fd_next = fifo_data;
    if (rd && fifo_q.size() != 0) fd_next = fifo_q.pop_front();
    if (wr_seen) begin
      if (fifo_q.size() < CAP || rd) begin
        fifo_q.push_back(wr_data);
        exp_q.push_back(wr_data);
      end else begin
        drop_model = 1'b1;
      end
    end
    @(posedge clk);
    edges++;
    #1 fifo_data = fd_next;
    @(negedge clk);
  endtask

  task automatic do_reset();
    wr_seen = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_err, 0);
    check("rst_data", m_data, 0);
    fifo_q.delete();
    exp_q.delete();
    drop_model = 1'b0;
    hold_prev  = 1'b0;
    fifo_data  = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int guard = 0;
    wr_seen = 1'b0;
    m_ready = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && guard < budget) begin
      cycle();
      guard++;
    end
    check("drained", exp_q.size(), 0);
  endtask

  task automatic burst(input bit mid_reset);
    logic [WIDTH-1:0] v[6];
    int               e0, guard;
    v = '{8'hA0, 8'hA1, 8'hAA, 8'hAB, 8'hAC, 8'hAD};
    do_reset();
    clear_stats();
    m_ready = 1'b1;
    e0 = edges + 1;
    for (int i = 0; i < 6; i++) begin
      wr_seen = 1'b1;
      wr_data = v[i];
      cycle();
      if (mid_reset && pops >= 3) break;
    end
    wr_seen = 1'b0;
    if (mid_reset) begin
      guard = 0;
      while (pops < 3 && guard < 10) begin cycle(); guard++; end
      check("mid_pops", pops, 3);
      do_reset();
      clear_stats();
      m_ready = 1'b1;
      wr_seen = 1'b1;
      wr_data = 8'd55;
      cycle();
      e0 = edges;
      wr_seen = 1'b0;
      guard = 0;
      while (pops < 1 && guard < 10) begin cycle(); guard++; end
      check("mid_lat", first_valid_edge - e0, 2);
      check("mid_first", last_pop, 55);
      check("mid_pops2", pops, 1);
    end else begin
      guard = 0;
      while (pops < 6 && guard < 20) begin cycle(); guard++; end
      check("burst_pops", pops, 6);
      check("burst_lat", first_valid_edge - e0, 2);
      check("burst_consec", last_pop_edge - first_pop_edge, 5);
      check("burst_maxlvl", max_level, 1);
      check("burst_end_valid", m_valid, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    edges = 0;
    drop_model = 1'b0;
    hold_prev = 1'b0;
    clear_stats();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // random prior state, then reset between edges
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_seen = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      cycle();
    end
    burst(1'b0);

    // backpressure
    do_reset();
    clear_stats();
    m_ready = 1'b0;
    wr_seen = 1'b1; wr_data = 8'hA0; cycle();
    wr_data = 8'hA1; cycle();
    wr_data = 8'hAA; cycle();
    wr_seen = 1'b0;
    repeat (5) cycle();
    check("bp_rd_pulses", rd_pulses, 2);
    check("bp_level", fifo_level, 1);
    check("bp_valid", m_valid, 1);
    check("bp_data", m_data, 8'hA0);
    m_ready = 1'b1;
    guard = 0;
    while (pops < 3 && guard < 10) begin cycle(); guard++; end
    check("bp_pops", pops, 3);
    check("bp_consec", last_pop_edge - first_pop_edge, 2);
    check("bp_end_valid", m_valid, 0);
    check("bp_end_level", fifo_level, 0);

    // fill and overflow
    do_reset();
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 66; i++) begin
      wr_seen = 1'b1; wr_data = 8'(i); cycle();
    end
    wr_seen = 1'b0;
    repeat (3) cycle();
    check("fill_level", fifo_level, 64);
    check("fill_drop", drop_err, 0);
    wr_seen = 1'b1; wr_data = 8'd66; cycle();
    wr_seen = 1'b0; cycle();
    check("ovf_drop", drop_err, 1);
    check("ovf_level", fifo_level, 64);
    clear_stats();
    drain(200);
    check("ovf_pops", pops, 66);
    check("ovf_last", last_pop, 65);

    // full with simultaneous read and write
    do_reset();
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 66; i++) begin
      wr_seen = 1'b1; wr_data = 8'(i); cycle();
    end
    wr_seen = 1'b0;
    repeat (2) cycle();
    max_level = 0; min_level = 999;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_seen = 1'b1; wr_data = 8'($urandom); cycle();
    end
    check("full_rw_min", min_level, 64);
    check("full_rw_max", max_level, 64);
    check("full_rw_drop", drop_err, 0);
    drain(200);

    burst(1'b1);
    drain(20);

    // randomized traffic with varying pressure and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int wr_pct, rdy_pct;
      if (i % 250 == 0) begin
        wr_pct  = $urandom_range(10, 100);
        rdy_pct = $urandom_range(0, 100);
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      wr_seen = 1'($urandom_range(1, 100) <= wr_pct);
      wr_data = 8'($urandom);
      m_ready = 1'($urandom_range(1, 100) <= rdy_pct);
      cycle();
    end
    drain(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
